// File: rtl/reg_ctl_pkg.sv
// Shared types and helpers for the reg8 write arbiter: FSM state encoding,
// default sizes and a one-hot to index converter.
package reg_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2,
      ACKS  = 2'd3
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 8;

   // Sized for the largest supported requester count; callers zero-pad.
   function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection for the write arbiter. Round-robin from ptr by
// default; defining ARB_FIXED_PRIO_EN switches to lowest-index-wins.
module rr_pick
   import reg_ctl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

`ifdef ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      winner = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end
`else
   logic [NREQ-1:0] rot_req;
   logic [NREQ-1:0] rot_win;
   logic [NREQ-1:0] unused_rot_hi;
   logic [NREQ-1:0] unused_win_lo;

   // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
   always_comb begin
      {unused_rot_hi, rot_req} = {req, req} >> ptr;
      rot_win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            rot_win    = '0;
            rot_win[i] = 1'b1;
         end
      end
      {winner, unused_win_lo} = {rot_win, rot_win} << ptr;
   end
`endif

   assign valid = |req;

endmodule

// File: rtl/reg8_wr_arbiter.sv
// Shares one W-bit register between NREQ requesters: grant, capture, one-cycle
// write strobe, then ACK. ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module reg8_wr_arbiter
   import reg_ctl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ*W-1:0] DIN,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   ACK,
   output logic [W-1:0]      REG_D,
   output logic              REG_WE,
   output logic              BUSY
);

   localparam int PW = $clog2(NREQ);

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] winner;
   logic            valid;
   logic [NREQ-1:0] gnt_nxt;
   logic [NREQ-1:0] ack_nxt;
   logic            we_nxt;
   logic [W-1:0]    d_nxt;
   logic [W-1:0]    din_sel;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (REQ),
      .ptr    (ptr),
      .winner (winner),
      .valid  (valid)
   );

   always_ff @(posedge CLK) begin
      if (CLR) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid) state_nxt = GRANT;
         GRANT:   state_nxt = WRITE;
         WRITE:   state_nxt = ACKS;
         ACKS:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      din_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner[i]) din_sel = din_sel | DIN[i*W +: W];
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   logic [7:0] gnt_wide;
   logic [2:0] gnt_idx;

   always_comb begin
      gnt_wide           = '0;
      gnt_wide[NREQ-1:0] = GNT;
      gnt_idx            = onehot2idx(gnt_wide);
   end
`endif

   // Next values for the registered outputs; GNT stays up from GRANT through ACKS.
   always_comb begin
      gnt_nxt = GNT;
      ack_nxt = '0;
      we_nxt  = 1'b0;
      d_nxt   = REG_D;
      ptr_nxt = ptr;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (valid) begin
               gnt_nxt = winner;
               d_nxt   = din_sel;
            end
         end
         GRANT: we_nxt  = 1'b1;
         WRITE: ack_nxt = GNT;
         ACKS: begin
            gnt_nxt = '0;
`ifdef ARB_FIXED_PRIO_EN
            ptr_nxt = '0;
`else
            if (gnt_idx == 3'(NREQ - 1)) ptr_nxt = '0;
            else                         ptr_nxt = PW'(gnt_idx + 3'd1);
`endif
         end
         default: gnt_nxt = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         GNT    <= '0;
         ACK    <= '0;
         REG_D  <= '0;
         REG_WE <= 1'b0;
         ptr    <= '0;
      end else begin
         GNT    <= gnt_nxt;
         ACK    <= ack_nxt;
         REG_D  <= d_nxt;
         REG_WE <= we_nxt;
         ptr    <= ptr_nxt;
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// Self-checking bench for reg8_wr_arbiter: directed scenarios plus randomized
// requesters, compared every cycle against a transaction-level schedule model.
module tb_reg8_wr_arbiter;

   logic        CLK = 1'b0;
   logic        CLR = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] din = '0;
   logic [3:0]  GNT;
   logic [3:0]  ACK;
   logic [7:0]  REG_D;
   logic        REG_WE;
   logic        BUSY;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   reg8_wr_arbiter #(.NREQ(4), .W(8)) dut (
      .CLK    (CLK),
      .CLR    (CLR),
      .REQ    (req),
      .DIN    (din),
      .GNT    (GNT),
      .ACK    (ACK),
      .REG_D  (REG_D),
      .REG_WE (REG_WE),
      .BUSY   (BUSY)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [3:0] ack;
      logic       we;
      logic       busy;
      logic [7:0] d;
   } rec_t;

   rec_t cur_exp;
   rec_t exp_q[$];
   int   m_ptr = 0;
   logic [7:0] m_last_d = '0;
   bit   model_valid = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic clr_v, input logic [3:0] req_v, input logic [31:0] din_v);
      CLR = clr_v;
      req = req_v;
      din = din_v;
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Each accepted request schedules the outputs of the next four cycles at once.
   initial begin
      int   w;
      logic [7:0] d;
      logic [3:0] g;
      forever begin
         @(posedge CLK);
         if (CLR) begin
            exp_q.delete();
            m_ptr       = 0;
            m_last_d    = '0;
            cur_exp     = '0;
            model_valid = 1'b1;
         end else if (model_valid) begin
            if (exp_q.size() > 0) begin
               cur_exp = exp_q.pop_front();
            end else begin
               w = -1;
`ifdef ARB_FIXED_PRIO_EN
               for (int k = 3; k >= 0; k--) if (req[k]) w = k;
`else
               for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`endif
               if (w >= 0) begin
                  d        = 8'(din >> (8 * w));
                  g        = 4'(1 << w);
                  m_last_d = d;
`ifndef ARB_FIXED_PRIO_EN
                  m_ptr    = (w + 1) % 4;
`endif
                  cur_exp = '{gnt: g, ack: 4'b0, we: 1'b0, busy: 1'b1, d: d};
                  exp_q.push_back('{gnt: g, ack: 4'b0, we: 1'b1, busy: 1'b1, d: d});
                  exp_q.push_back('{gnt: g, ack: g, we: 1'b0, busy: 1'b1, d: d});
                  exp_q.push_back('{gnt: 4'b0, ack: 4'b0, we: 1'b0, busy: 1'b0, d: d});
               end else begin
                  cur_exp = '{gnt: 4'b0, ack: 4'b0, we: 1'b0, busy: 1'b0, d: m_last_d};
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (model_valid) begin
            check_output("model_gnt",    32'(GNT),    32'(cur_exp.gnt));
            check_output("model_ack",    32'(ACK),    32'(cur_exp.ack));
            check_output("model_reg_we", 32'(REG_WE), 32'(cur_exp.we));
            check_output("model_busy",   32'(BUSY),   32'(cur_exp.busy));
            check_output("model_reg_d",  32'(REG_D),  32'(cur_exp.d));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] exp_order [5];
      bit         seen;
`ifdef ARB_FIXED_PRIO_EN
      exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

      // Reset held with every requester asking.
      tick();
      apply_stimulus(1'b1, 4'b1111, 32'h0);
      tick();
      tick();
      check_output("reset_gnt",    32'(GNT),    32'h0);
      check_output("reset_ack",    32'(ACK),    32'h0);
      check_output("reset_reg_we", 32'(REG_WE), 32'h0);
      check_output("reset_reg_d",  32'(REG_D),  32'h0);
      check_output("reset_busy",   32'(BUSY),   32'h0);
      apply_stimulus(1'b0, 4'b1111, 32'h0);
      tick();
      check_output("post_reset_gnt", 32'(GNT), 32'h1);
      apply_stimulus(1'b0, 4'b0000, 32'h0);
      repeat (3) tick();

      // Single request latency.
      apply_stimulus(1'b0, 4'b0100, 32'h00A5_0000);
      tick();
      check_output("lat_gnt",  32'(GNT),  32'h4);
      check_output("lat_busy", 32'(BUSY), 32'h1);
      tick();
      check_output("lat_we", 32'(REG_WE), 32'h1);
      check_output("lat_d",  32'(REG_D),  32'hA5);
      tick();
      check_output("lat_ack", 32'(ACK), 32'h4);
      req = 4'b0000;
      tick();
      check_output("lat_idle_busy", 32'(BUSY), 32'h0);

      // All four requesting, each re-raising after its ACK.
      apply_stimulus(1'b1, 4'b0000, 32'h0);
      tick();
      apply_stimulus(1'b0, 4'b1111, 32'h4433_2211);
      for (int k = 0; k < 5; k++) begin
         seen = 1'b0;
         for (int n = 0; n < 8 && !seen; n++) begin
            tick();
            if (GNT != 4'b0) seen = 1'b1;
         end
         check_output("order_gnt", 32'(GNT), 32'(exp_order[k]));
         seen = 1'b0;
         for (int n = 0; n < 8 && !seen; n++) begin
            tick();
            if (ACK != 4'b0) seen = 1'b1;
         end
         check_output("order_ack", 32'(ACK), 32'(exp_order[k]));
         req = req & ~exp_order[k];
         tick();
         if (k < 4) req = req | exp_order[k];
         else       req = 4'b0000;
      end

      // Data changed after capture must not reach the register.
      apply_stimulus(1'b0, 4'b0010, 32'h0000_3C00);
      tick();
      din = 32'h0000_FF00;
      tick();
      check_output("capture_we", 32'(REG_WE), 32'h1);
      check_output("capture_d",  32'(REG_D),  32'h3C);
      tick();
      check_output("capture_ack", 32'(ACK), 32'h2);
      req = 4'b0000;
      tick();

      // Reset during GRANT aborts before the strobe.
      apply_stimulus(1'b0, 4'b0100, 32'h005A_0000);
      tick();
      check_output("abort_gnt", 32'(GNT), 32'h4);
      CLR = 1'b1;
      tick();
      check_output("abort_we",   32'(REG_WE), 32'h0);
      check_output("abort_busy", 32'(BUSY),   32'h0);
      check_output("abort_gnt0", 32'(GNT),    32'h0);
      apply_stimulus(1'b0, 4'b1010, 32'h0);
      tick();
      check_output("abort_no_ack", 32'(ACK),    32'h0);
      check_output("abort_no_we",  32'(REG_WE), 32'h0);
      check_output("abort_ptr0",   32'(GNT),    32'h2);
      tick();
      tick();
      req = 4'b0000;
      tick();

      // Requester 3 drops REQ after capture; pointer then wraps to 0.
      apply_stimulus(1'b0, 4'b1000, 32'h7E00_0000);
      tick();
      req = 4'b0000;
      tick();
      check_output("drop_we", 32'(REG_WE), 32'h1);
      check_output("drop_d",  32'(REG_D),  32'h7E);
      tick();
      check_output("drop_ack", 32'(ACK), 32'h8);
      tick();
      req = 4'b1111;
      tick();
      check_output("wrap_gnt", 32'(GNT), 32'h1);
      req = 4'b0000;
      repeat (3) tick();

      // Randomized requesters obeying the handshake, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         CLR = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < 4; i++) begin
            if (ACK[i])                                       req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 3) == 0)    req[i] = 1'b1;
            else if (req[i] && $urandom_range(0, 31) == 0)    req[i] = 1'b0;
         end
         din = $urandom;
      end
      apply_stimulus(1'b0, 4'b0000, 32'h0);
      repeat (8) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
